exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_pkg.sv | 36 +++
 rtl/exec_sequencer_ir_decode.sv | 34 +++
 rtl/exec_sequencer.sv | 179 +++++++++++++++++
 tb/tb_exec_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared state encodings and instruction-word field layout for the execution sequencer.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int RA0_HI = 5;
  localparam int RA0_LO = 4;
  localparam int RA1_HI = 3;
  localparam int RA1_LO = 2;

  localparam logic [1:0] OPC_ADD = 2'd0;

  typedef struct packed {
    logic [1:0] opcode;
    logic [1:0] ra0;
    logic [1:0] ra1;
  } ir_fields_t;

  function automatic ir_fields_t split_ir(input logic [7:0] ir);
    ir_fields_t f;
    f.opcode = ir[OPC_HI:OPC_LO];
    f.ra0    = ir[RA0_HI:RA0_LO];
    f.ra1    = ir[RA1_HI:RA1_LO];
    return f;
  endfunction

endpackage

// File: rtl/exec_sequencer_ir_decode.sv
// Instruction register with field decode; IR[1:0] is carried but has no meaning.
module ir_decode
  import exec_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] instr,
  output logic [1:0] opcode,
  output logic [1:0] ra0,
  output logic [1:0] ra1,
  output logic [3:0] addrs
);

  logic [7:0] ir;
  ir_fields_t fields;
  logic       unused_ir_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= 8'h00;
    end else if (load) begin
      ir <= instr;
    end
  end

  assign fields         = split_ir(ir);
  assign opcode         = fields.opcode;
  assign ra0            = fields.ra0;
  assign ra1            = fields.ra1;
  assign addrs          = {fields.ra0, fields.ra1};
  assign unused_ir_bits = ^ir[1:0];

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute/memory/write-back sequencer driving an external ALU, register file and memory.
// States: IDLE wait run | FETCH instr handshake | DECODE read rf | EXEC alu | MEM data handshake | WB write/pc
module exec_sequencer
  import exec_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] pc,
  output logic       instr_req,
  input  logic       instr_ack,
  input  logic [7:0] instr,
  output logic [1:0] rf_ra0,
  output logic [1:0] rf_ra1,
  input  logic [7:0] rf_rd0,
  input  logic [7:0] rf_rd1,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic [7:0] rf_wd,
  output logic [1:0] alu_opcode,
  output logic [3:0] alu_addrs,
  output logic [7:0] alu_din0,
  output logic [7:0] alu_din1,
  input  logic [7:0] alu_dout,
  input  logic       alu_carry,
  input  logic       alu_borrow,
  input  logic       alu_carry_en,
  input  logic       alu_bcf,
  input  logic       alu_mem_write,
  input  logic       alu_mem_read,
  input  logic       alu_toggle,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       carry_flag,
  output logic       toggle_q,
  output logic       busy
);

  state_t     state;
  state_t     state_nxt;
  logic       ir_load;
  logic [1:0] opcode;
  logic [1:0] ra0;
  logic [1:0] ra1;
  logic [3:0] addrs;
  logic [7:0] op0;
  logic [7:0] op1;
  logic [7:0] result;
  logic       take;
  logic       mw;
  logic       mr;

  ir_decode u_ir_decode (
    .clk    (clk),
    .rst    (rst),
    .load   (ir_load),
    .instr  (instr),
    .opcode (opcode),
    .ra0    (ra0),
    .ra1    (ra1),
    .addrs  (addrs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    instr_req = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    rf_we     = 1'b0;
    alu_din0  = 8'h00;
    alu_din1  = 8'h00;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ack) begin
          ir_load   = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_din0  = op0;
        alu_din1  = op1;
        state_nxt = (alu_mem_write || alu_mem_read) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = mw;
        mem_addr  = op0;
        mem_wdata = op1;
        if (mem_ack) begin
          state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        // branches and stores retire without touching the register file
        rf_we     = !take && !mw;
        state_nxt = run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= 8'h00;
      op0        <= 8'h00;
      op1        <= 8'h00;
      result     <= 8'h00;
      take       <= 1'b0;
      mw         <= 1'b0;
      mr         <= 1'b0;
      carry_flag <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      case (state)
        ST_DECODE: begin
          op0 <= rf_rd0;
          op1 <= rf_rd1;
        end
        ST_EXEC: begin
          result <= alu_dout;
          take   <= alu_bcf;
          mw     <= alu_mem_write;
          mr     <= alu_mem_read;
          if (alu_carry_en) begin
            carry_flag <= (opcode == OPC_ADD) ? alu_carry : alu_borrow;
          end
          if (alu_toggle) begin
            toggle_q <= !toggle_q;
          end
        end
        ST_MEM: begin
          if (mem_ack && mr) begin
            result <= mem_rdata;
          end
        end
        ST_WB: begin
          pc <= take ? result : pc + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign rf_ra0     = ra0;
  assign rf_ra1     = ra1;
  assign rf_wa      = ra0;
  assign rf_wd      = result;
  assign alu_opcode = opcode;
  assign alu_addrs  = addrs;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench: stimulus pushes expected fetch/memory/write-back events; a monitor pops and compares.
module tb_exec_sequencer;

  localparam int K_FETCH = 0;
  localparam int K_MEM   = 1;
  localparam int K_WB    = 2;

  localparam int M_BRANCH = 0;
  localparam int M_MEMW   = 1;
  localparam int M_MEMR   = 2;
  localparam int M_TOGGLE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] pc;
  logic       instr_req;
  logic       instr_ack;
  logic [7:0] instr;
  logic [1:0] rf_ra0, rf_ra1;
  logic [7:0] rf_rd0, rf_rd1;
  logic       rf_we;
  logic [1:0] rf_wa;
  logic [7:0] rf_wd;
  logic [1:0] alu_opcode;
  logic [3:0] alu_addrs;
  logic [7:0] alu_din0, alu_din1, alu_dout;
  logic       alu_carry, alu_borrow, alu_carry_en, alu_bcf;
  logic       alu_mem_write, alu_mem_read, alu_toggle;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       carry_flag, toggle_q, busy;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
    logic       we;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mem_cycles = 0;

  logic [7:0] rf   [4];
  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  int         op3_mode  = M_BRANCH;
  logic [7:0] br_target = 8'h00;
  int         ilat = 1;
  int         mlat = 1;
  int         icnt = 0;
  int         mcnt = 0;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc),
    .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_opcode(alu_opcode), .alu_addrs(alu_addrs), .alu_din0(alu_din0), .alu_din1(alu_din1),
    .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_borrow(alu_borrow), .alu_carry_en(alu_carry_en),
    .alu_bcf(alu_bcf), .alu_mem_write(alu_mem_write), .alu_mem_read(alu_mem_read), .alu_toggle(alu_toggle),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .carry_flag(carry_flag), .toggle_q(toggle_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // environment: instruction/data memories with programmable ack latency, register file, ALU
  assign instr     = imem[pc];
  assign instr_ack = instr_req && (icnt == ilat - 1);
  assign mem_ack   = mem_req && (mcnt == mlat - 1);
  assign mem_rdata = dmem[mem_addr];
  assign rf_rd0    = rf[rf_ra0];
  assign rf_rd1    = rf[rf_ra1];

  always @(posedge clk) begin
    icnt <= instr_req ? icnt + 1 : 0;
    mcnt <= mem_req ? mcnt + 1 : 0;
  end

  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] = rf_wd;
    if (mem_req && mem_ack && mem_we) dmem[mem_addr] = mem_wdata;
  end

  always_comb begin
    alu_dout      = 8'h00;
    alu_carry     = 1'b0;
    alu_borrow    = 1'b0;
    alu_carry_en  = 1'b0;
    alu_bcf       = 1'b0;
    alu_mem_write = 1'b0;
    alu_mem_read  = 1'b0;
    alu_toggle    = 1'b0;
    case (alu_opcode)
      2'd0: begin
        {alu_carry, alu_dout} = {1'b0, alu_din0} + {1'b0, alu_din1};
        alu_carry_en = 1'b1;
      end
      2'd1: begin
        alu_dout     = alu_din0 - alu_din1;
        alu_borrow   = alu_din0 < alu_din1;
        alu_carry_en = 1'b1;
      end
      2'd2: alu_dout = alu_din0 ^ alu_din1;
      default: begin
        alu_dout = alu_din0;
        case (op3_mode)
          M_BRANCH: begin alu_bcf = 1'b1; alu_dout = br_target; end
          M_MEMW:   alu_mem_write = 1'b1;
          M_MEMR:   alu_mem_read = 1'b1;
          default:  alu_toggle = 1'b1;
        endcase
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input logic we);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d; e.we = we;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("req_exclusive", 32'(int'(instr_req) + int'(mem_req) + int'(rf_we) <= 1), 32'd1);
      if (mem_req) mem_cycles++;
      if ((instr_req && instr_ack) || (mem_req && mem_ack) || rf_we) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: req=%b mem=%b we=%b expected no event", instr_req, mem_req, rf_we);
        end else begin
          e = sb.pop_front();
          if (instr_req) begin
            check("fetch_kind", K_FETCH, e.kind);
            check("fetch_pc", pc, e.a);
          end else if (mem_req) begin
            check("mem_kind", K_MEM, e.kind);
            check("mem_we", mem_we, e.we);
            check("mem_addr", mem_addr, e.a);
            check("mem_wdata", mem_wdata, e.d);
          end else begin
            check("wb_kind", K_WB, e.kind);
            check("wb_addr", rf_wa, e.a);
            check("wb_alu_addrs", alu_addrs[3:2], e.a[1:0]);
            check("wb_data", rf_wd, e.d);
          end
        end
      end
    end
  end

  task automatic run_one(output int cyc);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    cyc = 0;
    while (busy && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int m0;
    int k;
    foreach (imem[i]) imem[i] = 8'h00;
    foreach (dmem[i]) dmem[i] = 8'h00;
    imem[8'h00] = 8'h18; imem[8'h01] = 8'h3C; imem[8'h02] = 8'h44; imem[8'h03] = 8'hA4;
    imem[8'h04] = 8'hC8; imem[8'h05] = 8'hD0; imem[8'h06] = 8'hFC; imem[8'h07] = 8'hC0;
    imem[8'h40] = 8'hC0; imem[8'hFF] = 8'h80;
    dmem[8'h02] = 8'h5A;
    rf[0] = 8'h01; rf[1] = 8'hF0; rf[2] = 8'h20; rf[3] = 8'h05;

    repeat (3) @(negedge clk);
    check("rst_pc", pc, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_instr_req", instr_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_carry", carry_flag, 1'b0);
    check("idle_toggle", toggle_q, 1'b0);

    // add F0+20 -> r1=10, carry
    push(K_FETCH, 8'h00, 8'h00, 1'b0); push(K_WB, 8'h01, 8'h10, 1'b0);
    run_one(cyc);
    check("add_latency", cyc, 4); check("add_carry", carry_flag, 1'b1); check("add_pc", pc, 8'h01);

    // add 05+05 -> r3=0A, carry cleared
    push(K_FETCH, 8'h01, 8'h00, 1'b0); push(K_WB, 8'h03, 8'h0A, 1'b0);
    run_one(cyc);
    check("add2_carry", carry_flag, 1'b0); check("add2_pc", pc, 8'h02);

    // sub 01-02 -> r0=FF with borrow
    rf[1] = 8'h02;
    push(K_FETCH, 8'h02, 8'h00, 1'b0); push(K_WB, 8'h00, 8'hFF, 1'b0);
    run_one(cyc);
    check("sub_borrow", carry_flag, 1'b1); check("sub_pc", pc, 8'h03);

    // xor 20^02 -> r2=22, carry held
    push(K_FETCH, 8'h03, 8'h00, 1'b0); push(K_WB, 8'h02, 8'h22, 1'b0);
    run_one(cyc);
    check("xor_carry_held", carry_flag, 1'b1); check("xor_pc", pc, 8'h04);

    // store with 3-cycle ack
    op3_mode = M_MEMW; mlat = 3; m0 = mem_cycles;
    push(K_FETCH, 8'h04, 8'h00, 1'b0); push(K_MEM, 8'hFF, 8'h22, 1'b1);
    run_one(cyc);
    check("store_latency", cyc, 7); check("store_req_cycles", mem_cycles - m0, 3);
    check("store_pc", pc, 8'h05); check("store_dmem", dmem[8'hFF], 8'h22);

    // load from addr 02 -> r1=5A
    op3_mode = M_MEMR; mlat = 1;
    push(K_FETCH, 8'h05, 8'h00, 1'b0); push(K_MEM, 8'h02, 8'hFF, 1'b0); push(K_WB, 8'h01, 8'h5A, 1'b0);
    run_one(cyc);
    check("load_latency", cyc, 5); check("load_pc", pc, 8'h06);

    // toggle, writes back din0
    op3_mode = M_TOGGLE;
    push(K_FETCH, 8'h06, 8'h00, 1'b0); push(K_WB, 8'h03, 8'h0A, 1'b0);
    run_one(cyc);
    check("toggle_q", toggle_q, 1'b1); check("toggle_carry_held", carry_flag, 1'b1);

    // branch to 40, then to FF
    op3_mode = M_BRANCH; br_target = 8'h40;
    push(K_FETCH, 8'h07, 8'h00, 1'b0);
    run_one(cyc);
    check("branch_latency", cyc, 4); check("branch_pc", pc, 8'h40);
    br_target = 8'hFF;
    push(K_FETCH, 8'h40, 8'h00, 1'b0);
    run_one(cyc);
    check("branch2_pc", pc, 8'hFF);

    // xor at FF wraps pc to 00
    push(K_FETCH, 8'hFF, 8'h00, 1'b0); push(K_WB, 8'h00, 8'h00, 1'b0);
    run_one(cyc);
    check("wrap_pc", pc, 8'h00);

    // add 5A+22 with instr_ack after 3 cycles
    ilat = 3;
    push(K_FETCH, 8'h00, 8'h00, 1'b0); push(K_WB, 8'h01, 8'h7C, 1'b0);
    run_one(cyc);
    check("iwait_latency", cyc, 6); check("iwait_carry", carry_flag, 1'b0); check("iwait_pc", pc, 8'h01);
    ilat = 1;

    // reset in the second memory wait cycle
    imem[8'h01] = 8'hC8; op3_mode = M_MEMW; mlat = 5;
    push(K_FETCH, 8'h01, 8'h00, 1'b0);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    k = 0;
    while (!mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mem_req_reached", mem_req, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mid_pc", pc, 8'h00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_toggle", toggle_q, 1'b0);
    check("rst_mid_rf_we", rf_we, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    check("post_rst_pc", pc, 8'h00);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
